unary_stream_encoder: RTL and testbench
=======================================

UNARY_STREAM_ENCODER -- requirements
Module: unary_stream_encoder

Interface
REQ-001 The block SHALL have these parameters: INPUT_WIDTH, 32, stream length in bits per frame.
REQ-002 The block SHALL have these parameters: COUNT_WIDTH, $clog2(INPUT_WIDTH+1), width of value and counters.
REQ-003 The block SHALL have these parameters: MODE, 1, encoding selector (0 = thermometer, 1 = distributed).
REQ-004 Reset and clock SHALL be: reset reset, asynchronous, active-low; clock clk.
REQ-005 Ports SHALL be:
  - clk  in  1  clock
  - reset  in  1  async active-low reset
  - in_value  in  COUNT_WIDTH  binary count of ones to encode
  - in_valid  in  1  in_value offered
  - in_ready  out  1  encoder can accept a new value
  - bit_ready  in  1  downstream accepts the current bit
  - bit_out  out  1  current unary bit
  - bit_valid  out  1  bit_out is meaningful
  - bit_count  out  COUNT_WIDTH  number of bits transferred in the current frame
  - done  out  1  one-cycle pulse after the final bit of a frame is transferred

Function
REQ-006 The FSM SHALL have two states, IDLE and STREAM; in_ready SHALL be 1 exactly in IDLE, and bit_valid SHALL be 1 exactly in STREAM.
REQ-007 In IDLE, when in_valid is 1, the block SHALL latch min(in_value, INPUT_WIDTH), clear bit_count to 0, initialise the accumulator to INPUT_WIDTH/2 (floor), and enter STREAM on the next edge, so bit_valid rises one cycle after the handshake.
REQ-008 A bit transfer SHALL occur on a rising edge where bit_valid && bit_ready.
  - On each transfer, bit_count SHALL increment by 1.
  - In MODE 1, the accumulator SHALL update to acc+value-INPUT_WIDTH if acc+value >= INPUT_WIDTH, otherwise to acc+value.
REQ-009 bit_out SHALL be combinational from registered state:
  - MODE 0: bit_out = (bit_count < value).
  - MODE 1: bit_out = (acc + value >= INPUT_WIDTH).
  - When bit_valid is 0, bit_out SHALL be 0.
REQ-010 The accumulator and sum SHALL be COUNT_WIDTH+1 bits wide, and no overflow SHALL occur for any value up to INPUT_WIDTH.
REQ-011 The total number of ones in each frame SHALL equal the latched value exactly in both modes.
REQ-012 While bit_ready is 0 in STREAM, bit_out, bit_count and acc SHALL hold stable (no drop, no repeat).
REQ-013 When the INPUT_WIDTH-th transfer occurs, the block SHALL return to IDLE and assert done for exactly one cycle on the next edge; bit_count SHALL hold INPUT_WIDTH until the next load.
REQ-014 in_valid asserted during STREAM SHALL be ignored; the value is not latched, and the producer holds it until in_ready is 1.
REQ-015 An in_value of 0 SHALL produce INPUT_WIDTH zeros, and any in_value >= INPUT_WIDTH SHALL produce INPUT_WIDTH ones.

Reset
REQ-016 On reset low, the block SHALL asynchronously enter IDLE with bit_valid=0, bit_out=0, done=0, bit_count=0, acc=0, value=0, and in_ready=1 after deassertion.
REQ-017 A reset asserted mid-frame SHALL abort the frame with no done pulse, and the next frame SHALL start only from a new in_valid handshake.

Structure
REQ-018 A shared package unary_pkg SHALL hold the state enum (IDLE, STREAM) and the MODE constants (UNARY_THERMO=0, UNARY_DISTRIB=1).
REQ-019 The rate-accumulator datapath (acc register, sum, compare, bit_out) SHALL be one sub-module named unary_rate_accumulator; the FSM and counters SHALL stay in the top.

Verification
REQ-020 The bench SHALL cover: W=32, MODE 1, value 8, bit_ready=1 -> ones at bit indices 1,5,9,...,29 (8 ones); done one cycle after the 32nd transfer.
REQ-021 The bench SHALL cover: MODE 0, value 5 -> bits 0-4 are 1 and bits 5-31 are 0; bit_count reaches 32.
REQ-022 The bench SHALL cover: value 0 -> 32 zeros; value 32 -> 32 ones; value 40 -> 32 ones (saturation).
REQ-023 The bench SHALL cover: bit_ready low for 3 cycles at bit_count=10 -> bit_out and bit_count are unchanged across the stall, and the frame still has exactly value ones.
REQ-024 The bench SHALL cover: in_valid pulsed with value 3 during STREAM -> ignored, and the current frame's ones count is unchanged.
REQ-025 The bench SHALL cover: reset asserted at bit_count=12 -> next cycle bit_valid=0, bit_count=0, in_ready=1, no done; then a reload of value 16 yields a clean 32-bit frame with 16 ones.

Source files
------------

// File: rtl/unary_pkg.sv
// Shared types and constants for the unary stream encoder: FSM state
// encoding and the encoding-mode selector values.
package unary_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam int UNARY_THERMO  = 0;
    localparam int UNARY_DISTRIB = 1;

endpackage

// File: rtl/unary_rate_accumulator.sv
// Rate-accumulator datapath: holds the fractional accumulator and produces the
// current unary bit (thermometer compare or evenly distributed overflow).
module unary_rate_accumulator
    import unary_pkg::*;
#(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1),
    parameter int MODE        = UNARY_DISTRIB
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   advance,
    input  logic                   active,
    input  logic [COUNT_WIDTH-1:0] value,
    input  logic [COUNT_WIDTH-1:0] bit_count,
    output logic                   bit_out
);

    // One extra bit keeps acc + value (< 2*INPUT_WIDTH) from wrapping.
    localparam logic [COUNT_WIDTH:0] FRAME_LEN = (COUNT_WIDTH + 1)'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH:0] ACC_INIT  = (COUNT_WIDTH + 1)'(INPUT_WIDTH / 2);

    logic [COUNT_WIDTH:0] acc_q;
    logic [COUNT_WIDTH:0] acc_d;
    logic [COUNT_WIDTH:0] sum;
    logic                 overflow;

    assign sum      = acc_q + {1'b0, value};
    assign overflow = (sum >= FRAME_LEN);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        acc_d = acc_q;
        if (load) begin
            acc_d = ACC_INIT;
        end else if (advance && (MODE == UNARY_DISTRIB)) begin
            acc_d = overflow ? (sum - FRAME_LEN) : sum;
        end
    end

    always_comb begin
        bit_out = 1'b0;
        if (active) begin
            bit_out = (MODE == UNARY_THERMO) ? (bit_count < value) : overflow;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/unary_stream_encoder.sv
// Converts a binary count into an INPUT_WIDTH-bit unary frame streamed one bit
// per ready/valid transfer, with a done pulse after the last bit.
module unary_stream_encoder
    import unary_pkg::*;
#(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1),
    parameter int MODE        = UNARY_DISTRIB
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COUNT_WIDTH-1:0] in_value,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   bit_ready,
    output logic                   bit_out,
    output logic                   bit_valid,
    output logic [COUNT_WIDTH-1:0] bit_count,
    output logic                   done
);

    localparam logic [COUNT_WIDTH-1:0] FRAME_LEN = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] LAST_IDX  = COUNT_WIDTH'(INPUT_WIDTH - 1);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] value_q, value_d;
    logic [COUNT_WIDTH-1:0] bit_count_q, bit_count_d;
    logic                   done_q, done_d;
    logic                   load;
    logic                   advance;

    assign in_ready  = (state_q == IDLE);
    assign bit_valid = (state_q == STREAM);
    assign bit_count = bit_count_q;
    assign done      = done_q;
    assign load      = in_ready && in_valid;
    assign advance   = bit_valid && bit_ready;

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        bit_count_d = bit_count_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    value_d     = (in_value > FRAME_LEN) ? FRAME_LEN : in_value;
                    bit_count_d = '0;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (bit_ready) begin
                    bit_count_d = bit_count_q + COUNT_WIDTH'(1);
                    // bit_count stays at FRAME_LEN after the last bit until the next load.
                    if (bit_count_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            value_q     <= '0;
            bit_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            bit_count_q <= bit_count_d;
            done_q      <= done_d;
        end
    end

    unary_rate_accumulator #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH),
        .MODE        (MODE)
    ) u_rate_acc (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .advance   (advance),
        .active    (bit_valid),
        .value     (value_q),
        .bit_count (bit_count_q),
        .bit_out   (bit_out)
    );

endmodule

// File: tb/tb_unary_stream_encoder.sv
// Bench for unary_stream_encoder: a distributed-mode and a thermometer-mode
// instance share stimulus and are compared every cycle against a frame model.
module tb_unary_stream_encoder;
    import unary_pkg::*;

    localparam int W  = 32;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] in_value = '0;
    logic          in_valid = 1'b0;
    logic          bit_ready = 1'b0;

    logic          in_ready_d, bit_out_d, bit_valid_d, done_d;
    logic [CW-1:0] bit_count_d;
    logic          in_ready_t, bit_out_t, bit_valid_t, done_t;
    logic [CW-1:0] bit_count_t;

    always #5 clk = ~clk;

    unary_stream_encoder #(.INPUT_WIDTH(W), .COUNT_WIDTH(CW), .MODE(UNARY_DISTRIB)) dut_d (
        .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid),
        .in_ready(in_ready_d), .bit_ready(bit_ready), .bit_out(bit_out_d),
        .bit_valid(bit_valid_d), .bit_count(bit_count_d), .done(done_d)
    );

    unary_stream_encoder #(.INPUT_WIDTH(W), .COUNT_WIDTH(CW), .MODE(UNARY_THERMO)) dut_t (
        .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid),
        .in_ready(in_ready_t), .bit_ready(bit_ready), .bit_out(bit_out_t),
        .bit_valid(bit_valid_t), .bit_count(bit_count_t), .done(done_t)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    // Bit i of a frame: thermometer is i < v; distributed is 1 when the running
    // total W/2 + i*v crosses a multiple of W on step i.
    function automatic int exp_bit(input int mode, input int v, input int i);
        if (mode == UNARY_THERMO) return (i < v) ? 1 : 0;
        return (((W / 2 + (i + 1) * v) / W) != ((W / 2 + i * v) / W)) ? 1 : 0;
    endfunction

    // Frame-level model: active frame, bits sent, saturated value, done pulse.
    bit m_active;
    int m_count;
    int m_value;
    bit m_done;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_count  <= 0;
            m_value  <= 0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (!m_active) begin
                if (in_valid) begin
                    m_active <= 1'b1;
                    m_count  <= 0;
                    m_value  <= (int'(in_value) > W) ? W : int'(in_value);
                end
            end else if (bit_ready) begin
                m_count <= m_count + 1;
                if (m_count == W - 1) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end
            end
        end
    end

    int   ones_d = 0, ones_t = 0;
    int   last_ones_d = -1, last_ones_t = -1;
    logic frame_d [W];
    logic frame_t [W];

    always @(negedge clk) begin
        check("in_ready_d",  in_ready_d,  !m_active);
        check("in_ready_t",  in_ready_t,  !m_active);
        check("bit_valid_d", bit_valid_d, m_active);
        check("bit_valid_t", bit_valid_t, m_active);
        check("bit_count_d", bit_count_d, m_count);
        check("bit_count_t", bit_count_t, m_count);
        check("done_d",      done_d,      m_done);
        check("done_t",      done_t,      m_done);
        check("bit_out_d", bit_out_d, m_active ? exp_bit(UNARY_DISTRIB, m_value, m_count) : 0);
        check("bit_out_t", bit_out_t, m_active ? exp_bit(UNARY_THERMO,  m_value, m_count) : 0);
        if (!reset) begin
            ones_d = 0;
            ones_t = 0;
        end else begin
            if (!m_active && in_valid) begin
                ones_d = 0;
                ones_t = 0;
            end
            if (m_active && bit_ready) begin
                ones_d += int'(bit_out_d);
                ones_t += int'(bit_out_t);
                frame_d[m_count] = bit_out_d;
                frame_t[m_count] = bit_out_t;
            end
            if (m_done) begin
                check("frame_ones_d", ones_d, m_value);
                check("frame_ones_t", ones_t, m_value);
                last_ones_d = ones_d;
                last_ones_t = ones_t;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        in_value = CW'(v);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic run_to_done(input string name, output int lat);
        lat = 0;
        bit_ready = 1'b1;
        while (!done_d && lat < 200) begin
            cycle();
            lat++;
        end
        if (lat >= 200) check({name, "_done_timeout"}, 0, 1);
        check({name, "_count_end_d"}, bit_count_d, W);
        check({name, "_count_end_t"}, bit_count_t, W);
        check({name, "_in_ready_end"}, in_ready_d, 1);
        cycle();
        check({name, "_done_one_cycle"}, done_d, 0);
    endtask

    task automatic wait_count(input int n);
        int guard = 0;
        while (int'(bit_count_d) != n && guard < 100) begin
            cycle();
            guard++;
        end
        if (guard >= 100) check("wait_count_timeout", 0, 1);
    endtask

    int      lat;
    logic    held_d, held_t;

    initial begin
        // Model pinned against hand-derived bits.
        check("model_d8_i0", exp_bit(UNARY_DISTRIB, 8, 0), 0);
        check("model_d8_i1", exp_bit(UNARY_DISTRIB, 8, 1), 1);
        check("model_d8_i5", exp_bit(UNARY_DISTRIB, 8, 5), 1);
        check("model_t5_i4", exp_bit(UNARY_THERMO, 5, 4), 1);
        check("model_t5_i5", exp_bit(UNARY_THERMO, 5, 5), 0);

        #1 reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        check("rst_in_ready",  in_ready_d,  1);
        check("rst_bit_valid", bit_valid_d, 0);
        check("rst_bit_out",   bit_out_d,   0);
        check("rst_bit_count", bit_count_d, 0);
        check("rst_done",      done_d,      0);

        // Distributed value 8: ones at 1,5,...,29; done 32 cycles after handshake.
        bit_ready = 1'b1;
        send(8);
        check("v8_bit_valid_rise", bit_valid_d, 1);
        run_to_done("v8", lat);
        check("v8_done_latency", lat, 32);
        for (int i = 0; i < W; i++) begin
            check($sformatf("v8_distrib_bit%0d", i), frame_d[i], (i % 4 == 1) ? 1 : 0);
        end
        check("v8_ones_d", last_ones_d, 8);

        // Thermometer value 5: bits 0-4 high.
        send(5);
        run_to_done("v5", lat);
        for (int i = 0; i < W; i++) begin
            check($sformatf("v5_thermo_bit%0d", i), frame_t[i], (i < 5) ? 1 : 0);
        end
        check("v5_ones_d", last_ones_d, 5);

        // Boundary values, including saturation above W.
        send(0);
        run_to_done("v0", lat);
        check("v0_ones_d", last_ones_d, 0);
        check("v0_ones_t", last_ones_t, 0);
        send(32);
        run_to_done("v32", lat);
        check("v32_ones_d", last_ones_d, 32);
        check("v32_ones_t", last_ones_t, 32);
        send(40);
        run_to_done("v40", lat);
        check("v40_ones_d", last_ones_d, 32);
        check("v40_ones_t", last_ones_t, 32);

        // Three-cycle stall at bit_count 10.
        send(12);
        wait_count(10);
        bit_ready = 1'b0;
        held_d = bit_out_d;
        held_t = bit_out_t;
        check("stall_thermo_bit10", held_t, 1);
        check("stall_distrib_bit10", held_d, 0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("stall_count", bit_count_d, 10);
            check("stall_bit_d", bit_out_d, held_d);
            check("stall_bit_t", bit_out_t, held_t);
        end
        run_to_done("stall", lat);
        check("stall_ones_d", last_ones_d, 12);
        check("stall_ones_t", last_ones_t, 12);

        // in_valid during STREAM is ignored.
        send(20);
        wait_count(6);
        in_value = CW'(3);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("ignore_in_ready", in_ready_d, 0);
        check("ignore_count", bit_count_d, 7);
        run_to_done("ignore", lat);
        check("ignore_ones_d", last_ones_d, 20);
        check("ignore_ones_t", last_ones_t, 20);

        // Reset mid-frame aborts without done; reload runs a clean frame.
        send(20);
        wait_count(12);
        reset = 1'b0;
        cycle();
        check("abort_bit_valid", bit_valid_d, 0);
        check("abort_bit_count", bit_count_d, 0);
        check("abort_in_ready",  in_ready_d,  1);
        check("abort_done",      done_d,      0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("abort_no_done", done_d, 0);
            check("abort_no_restart", bit_valid_d, 0);
        end
        send(16);
        run_to_done("reload", lat);
        check("reload_latency", lat, 32);
        check("reload_ones_d", last_ones_d, 16);
        check("reload_ones_t", last_ones_t, 16);

        bit_ready = 1'b0;
        cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
